adc_sample_averager: RTL and testbench
======================================

# adc_sample_averager

Downstream consumer of the flash ADC decoder's 2-bit output code. Synchronizes the code into the system clock domain and samples it at a programmable rate. It sums 2^LOG2_N consecutive samples and presents the window sum and the truncated average on a valid/ready output port. Results are produced back-to-back, and a sticky flag records any result lost to a slow consumer.

## Interface
- `LOG2_N`, default 3: log2 of samples per window (N = 8). Legal range 1..8.
- `DIV`, default 4: clock cycles per sample strobe. Legal range 1..256.
- `SUM_W`, default 2+LOG2_N (derived): width of the window sum.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: run enable. Low forces IDLE.
- `code`, in, 2: decoder output B[1:0]. Asynchronous to `clk`.
- `out_ready`, in, 1: consumer ready.
- `out_valid`, out, 1: result available.
- `out_sum`, out, SUM_W: sum of the N samples in the window.
- `out_avg`, out, 2: out_sum >> LOG2_N (truncation).
- `overrun`, out, 1: sticky flag. Set when an unconsumed result is overwritten.

## Operation
- `code` passes through a two-flop synchronizer per bit, giving `code_s`.
- FSM states:
  - IDLE: div_cnt=0, smp_cnt=0, acc=0.
  - ACCUM: IDLE→ACCUM when en=1. ACCUM→IDLE when en=0, checked every cycle. Leaving ACCUM clears acc, div_cnt, smp_cnt and overrun, and discards the partial window. out_valid and out_sum are retained until handshaken.
- div_cnt counts 0..DIV-1 in ACCUM and wraps. strobe = (div_cnt==DIV-1).
- On strobe: acc += code_s, with zero-extension to SUM_W so it never overflows (max 3·2^LOG2_N). smp_cnt increments.
- When strobe occurs with smp_cnt==N-1 (window end):
  - out_sum ← acc + code_s and out_valid ← 1.
  - acc and smp_cnt are reset to 0, and accumulation continues without a gap.
- Handshake: a transfer happens on a cycle with out_valid & out_ready. After a transfer out_valid drops next cycle, unless a window end occurs in the same cycle.
- Simultaneous window end and transfer: the new result loads, out_valid stays 1, overrun is unchanged.
- Window end while out_valid=1 and out_ready=0: the new result overwrites the old one and overrun ← 1.
- overrun is cleared only by reset or by leaving ACCUM.
- out_avg is combinational from out_sum.

## Timing
- Reset values: out_valid=0, out_sum=0, out_avg=0, overrun=0, state=IDLE, synchronizer flops=0.
- Input latency: a change on `code` is visible in code_s 2 cycles later.
- First strobe: the DIV-th cycle in ACCUM.
- out_valid rises on the edge after the N-th strobe, i.e. N·DIV edges after the edge that entered ACCUM. Subsequent results follow every N·DIV cycles.
- DIV=1: strobe every cycle in ACCUM.
- en low mid-window: IDLE on the next edge, with no output change except overrun→0.
- rst_n low mid-operation: all state reaches its reset values immediately (asynchronous). Leaving reset resumes on the first clk edge after rst_n rises.

## Structure
- Shared package `adc_pkg`:
  - `ADC_CODE_W = 2`.
  - FSM state typedef {IDLE, ACCUM}.
- One sub-module: `code_sync`, a parameterized-width two-flop synchronizer with asynchronous active-low reset.
- Everything else is flat in `adc_sample_averager`.

## Test plan
All scenarios use defaults LOG2_N=3, DIV=4.
- Reset held with code=3: all outputs 0. Release reset, en=1, code=3 constant, out_ready=1 → out_valid pulses every 32 cycles with out_sum=24, out_avg=3, overrun=0.
- code alternating 2'b01/2'b10 on each strobe: out_sum=12, out_avg=1. A sequence of four 3s and four 0s: out_sum=12, out_avg=1.
- out_ready=0 across two windows (code=2): out_valid stays 1, out_sum=16, overrun=1 after the second window end. Then en=0 → overrun=0, out_valid still 1. Then out_ready=1 → transfer, out_valid=0 next cycle.
- out_ready pulsed exactly in the cycle of a window end: no overrun, out_valid stays high, the new sum is presented.
- en dropped after 5 strobes, re-raised 10 cycles later with code=1: the first result is out_sum=8, with no contribution from the partial window.
- Asynchronous reset asserted mid-window between clock edges: outputs reach 0 before the next edge. After release, timing restarts from IDLE.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample averager: code width, FSM state type
// and a counter-width helper.
package adc_pkg;

  localparam int ADC_CODE_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Width of a counter that must hold 0..n-1; always at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/code_sync.sv
// Two-flop synchronizer, one chain per bit, for bringing the asynchronous
// decoder code into the system clock domain.
module code_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Samples the synchronized ADC code every DIV cycles, sums 2^LOG2_N samples
// per window and hands each window sum and average to a valid/ready consumer.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int LOG2_N = 3,
  parameter int DIV    = 4,
  parameter int SUM_W  = 2 + LOG2_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADC_CODE_W-1:0] code,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [SUM_W-1:0]      out_sum,
  output logic [ADC_CODE_W-1:0] out_avg,
  output logic                  overrun
);

  localparam int                DIV_W    = cnt_w(DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [LOG2_N-1:0] SMP_LAST = '1;

  state_t                  state;
  logic [ADC_CODE_W-1:0]   code_s;
  logic [DIV_W-1:0]        div_cnt;
  logic [LOG2_N-1:0]       smp_cnt;
  logic [SUM_W-1:0]        acc;
  logic [SUM_W-1:0]        acc_next;
  logic                    strobe;
  logic                    win_end;
  logic                    xfer;
  logic                    leave;

  code_sync #(
    .W (ADC_CODE_W)
  ) u_code_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (code),
    .q     (code_s)
  );

  // en low wins over a strobe in the same cycle: the partial window is dropped.
  assign leave    = (state == ACCUM) && !en;
  assign strobe   = (state == ACCUM) && en && (div_cnt == DIV_LAST);
  assign win_end  = strobe && (smp_cnt == SMP_LAST);
  assign acc_next = acc + SUM_W'(code_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      smp_cnt <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          smp_cnt <= '0;
          acc     <= '0;
          if (en) state <= ACCUM;
        end
        ACCUM: begin
          if (leave) begin
            state   <= IDLE;
            div_cnt <= '0;
            smp_cnt <= '0;
            acc     <= '0;
          end else begin
            div_cnt <= strobe ? '0 : div_cnt + 1'b1;
            if (strobe) begin
              smp_cnt <= smp_cnt + 1'b1;
              acc     <= win_end ? '0 : acc_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: a result moves on any cycle where out_valid and out_ready are
  // both high; out_valid/out_sum hold steady until then. A new window end
  // always loads, so a result still unaccepted at that moment is lost and
  // overrun is raised.
  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (win_end) begin
        out_valid <= 1'b1;
        out_sum   <= acc_next;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (leave) overrun <= 1'b0;
    end
  end

  assign out_avg = ADC_CODE_W'(out_sum >> LOG2_N);

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager at LOG2_N=3, DIV=4; results are
// checked against a queue of hand-computed expectations.
module tb_adc_sample_averager;

  localparam int SW = 5;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    code;
  logic          out_ready;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic [1:0]    out_avg;
  logic          overrun;

  // Scoreboard entry: {overrun, avg, sum}
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  adc_sample_averager dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .code      (code),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .overrun   (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic ovr, input logic [1:0] avg, input logic [SW-1:0] sum);
    exp_q.push_back({ovr, avg, sum});
  endtask

  // One window of 8 strobes; element i of seq is the code for strobe i.
  // Starts just after the edge that precedes the window, ends just after the
  // window-end edge.
  task automatic run_window(input logic [15:0] seq, input logic rdy);
    for (int i = 0; i < 8; i++) begin
      code = seq[2*i +: 2];
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        if (i == 0 && j == 0) out_ready = rdy;
        if (i == 7 && j == 2 && rdy) check("valid_before_end", 32'(out_valid), 32'd0);
      end
    end
    check("valid_at_end", 32'(out_valid), 32'd1);
  endtask

  // monitor: compare every accepted result against the scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum=%0d avg=%0d, required no result", out_sum, out_avg);
        end else begin
          e = exp_q.pop_front();
          check("result{ovr,avg,sum}", 32'({overrun, out_avg, out_sum}), 32'(e));
        end
      end
    end
  end

  // driver
  initial begin
    rst_n = 1'b0; en = 1'b0; code = 2'd3; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_avg", 32'(out_avg), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // constant 3, then alternating 1/2, then four 3s and four 0s
    rst_n = 1'b1;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0, 2'd3, 5'd24); run_window(16'hFFFF, 1'b1);
    push_exp(1'b0, 2'd3, 5'd24); run_window(16'hFFFF, 1'b1);
    push_exp(1'b0, 2'd1, 5'd12); run_window(16'h9999, 1'b1);
    push_exp(1'b0, 2'd1, 5'd12); run_window(16'h00FF, 1'b1);

    // consumer stalled across two windows of code 2
    run_window(16'hAAAA, 1'b0);
    check("stall1_overrun", 32'(overrun), 32'd0);
    run_window(16'hAAAA, 1'b0);
    check("stall2_overrun", 32'(overrun), 32'd1);
    check("stall2_sum", 32'(out_sum), 32'd16);
    en = 1'b0;
    @(posedge clk); #1;
    check("idle_overrun", 32'(overrun), 32'd0);
    check("idle_valid_held", 32'(out_valid), 32'd1);
    check("idle_sum_held", 32'(out_sum), 32'd16);
    push_exp(1'b0, 2'd2, 5'd16);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_after_xfer", 32'(out_valid), 32'd0);

    // ready pulsed exactly in the window-end cycle
    out_ready = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0, 2'd3, 5'd24);
    run_window(16'hFFFF, 1'b0);
    code = 2'd1;
    repeat (31) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pulse_valid", 32'(out_valid), 32'd1);
    check("pulse_sum", 32'(out_sum), 32'd8);
    check("pulse_avg", 32'(out_avg), 32'd1);
    check("pulse_overrun", 32'(overrun), 32'd0);
    push_exp(1'b0, 2'd1, 5'd8);
    out_ready = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check("pulse_drained", 32'(out_valid), 32'd0);

    // en dropped after 5 strobes of code 3, partial window discarded
    code = 2'd3; en = 1'b1;
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    en = 1'b0;
    code = 2'd1;
    repeat (10) begin @(posedge clk); #1; end
    check("partial_no_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0, 2'd1, 5'd8);
    run_window(16'h5555, 1'b1);

    // asynchronous reset between edges with a held result and overrun set
    run_window(16'hFFFF, 1'b0);
    run_window(16'hAAAA, 1'b0);
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_sum", 32'(out_sum), 32'd0);
    check("async_avg", 32'(out_avg), 32'd0);
    check("async_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(1'b0, 2'd2, 5'd16);
    run_window(16'hAAAA, 1'b1);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
